// File: rtl/boot_load_sequencer_if.sv
// Byte-stream handshake and instruction-RAM write bus seen by boot_load_sequencer.
// The master drives the stream and observes the RAM writes. The slave is the sequencer.
interface boot_load_sequencer_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [ADDR_W-1:0] inst_address;
   logic [DATA_W-1:0] inst_data;
   logic              inst_we;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  inst_address,
      input  inst_data,
      input  inst_we
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output inst_address,
      output inst_data,
      output inst_we
   );
endinterface

// File: rtl/boot_load_sequencer.sv
// Loads a length-prefixed byte stream into the core's instruction RAM, then runs
// the core until it is stopped or the run-cycle limit is reached.
module boot_load_sequencer #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 16,
   parameter int RUN_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 clr,
   boot_load_sequencer_if.slave bus,
   input  logic                 stop,
   output logic                 core_run,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     cycle_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int REM_W = ADDR_W + 1;
   localparam logic [CNT_W:0] RUN_LIMIT = (CNT_W + 1)'(RUN_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      HALT
   } state_t;

   state_t            state_q, state_d;
   logic [REM_W-1:0]  remaining_q, remaining_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic [ADDR_W-1:0] instAddr_q, instAddr_d;
   logic [DATA_W-1:0] instData_q, instData_d;
   logic              instWe_q, instWe_d;
   logic [CNT_W-1:0]  cycleCount_q, cycleCount_d;

   logic              accept;
   logic              limitHit;
   logic [REM_W-1:0]  lenDecoded;

   assign bus.in_ready     = (state_q != RUN);
   assign accept           = bus.in_valid & bus.in_ready;

   assign bus.inst_address = instAddr_q;
   assign bus.inst_data    = instData_q;
   assign bus.inst_we      = instWe_q;
   assign core_run         = (state_q == RUN);
   assign busy             = (state_q == LOAD) || (state_q == RUN);
   assign done             = (state_q == HALT);
   assign cycle_count      = cycleCount_q;

   // A zero length byte means a full RAM; oversize lengths clamp so the address never wraps.
   always_comb begin
      if ((bus.in_data == '0) || (32'(bus.in_data) > 32'(DEPTH))) begin
         lenDecoded = REM_W'(DEPTH);
      end else begin
         lenDecoded = REM_W'(bus.in_data);
      end
   end

   always_comb begin
      if (RUN_CYCLES == 0) begin
         limitHit = 1'b0;
      end else begin
         limitHit = (({1'b0, cycleCount_q} + (CNT_W + 1)'(1)) == RUN_LIMIT);
      end
   end

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      wrAddr_d     = wrAddr_q;
      instAddr_d   = instAddr_q;
      instData_d   = instData_q;
      instWe_d     = 1'b0;
      cycleCount_d = cycleCount_q;

      case (state_q)
         IDLE, HALT: begin
            if (accept) begin
               remaining_d = lenDecoded;
               wrAddr_d    = '0;
               state_d     = LOAD;
            end
         end

         LOAD: begin
            if (accept) begin
               instWe_d    = 1'b1;
               instData_d  = bus.in_data;
               instAddr_d  = wrAddr_q;
               wrAddr_d    = wrAddr_q + ADDR_W'(1);
               remaining_d = remaining_q - REM_W'(1);
               if (remaining_q == REM_W'(1)) begin
                  cycleCount_d = '0;
                  state_d      = RUN;
               end
            end
         end

         RUN: begin
            if (cycleCount_q != '1) begin
               cycleCount_d = cycleCount_q + CNT_W'(1);
            end
            if (stop || limitHit) begin
               state_d = HALT;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         wrAddr_q     <= '0;
         instAddr_q   <= '0;
         instData_q   <= '0;
         instWe_q     <= 1'b0;
         cycleCount_q <= '0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         wrAddr_q     <= wrAddr_d;
         instAddr_q   <= instAddr_d;
         instData_q   <= instData_d;
         instWe_q     <= instWe_d;
         cycleCount_q <= cycleCount_d;
      end
   end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Scoreboard bench: the driver predicts every RAM write and every run length.
// A free-running monitor checks them against what the sequencer actually produces.
module tb_boot_load_sequencer;

   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int CNT_W      = 16;
   localparam int RUN_CYCLES = 10;
   localparam int DEPTH      = 128;

   typedef struct {
      int addr;
      int data;
   } write_t;

   logic             clk = 1'b0;
   logic             clr;
   logic             stop;
   logic             core_run;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cycle_count;

   boot_load_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   boot_load_sequencer #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .RUN_CYCLES(RUN_CYCLES)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .bus        (bus),
      .stop       (stop),
      .core_run   (core_run),
      .busy       (busy),
      .done       (done),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   write_t          writeQ[$];
   int              runQ[$];
   logic [7:0]      presetData[$];
   int              testsRun    = 0;
   int              testsFailed = 0;
   int              weStreak    = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkReset(input string name);
      checkOutput({name, "_inst"}, {bus.inst_address, bus.inst_data, bus.inst_we}, 64'd0);
      checkOutput({name, "_status"}, {core_run, busy, done, bus.in_ready}, 64'b0001);
      checkOutput({name, "_count"}, cycle_count, 64'd0);
   endtask

   task automatic stepCycle();
      @(negedge clk);
      #1;
   endtask

   // Present one byte, with optional random idle cycles, until the sequencer takes it.
   task automatic sendByte(input logic [7:0] b, input int gapPct, output bit ok);
      int guard;
      guard = 0;
      ok    = 1'b0;
      while (!ok && guard < 200) begin
         stepCycle();
         stop = 1'($urandom_range(1));
         if (int'($urandom_range(99)) < gapPct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            ok           = bus.in_ready;
         end
         guard++;
      end
      if (!ok) checkOutput("acceptTimeout", 64'd0, 64'd1);
   endtask

   // One full boot: length byte, payload, then the run phase.
   // stopAt is the 1-based RUN cycle carrying stop (0 = none). abortCycle pulses clr in that RUN cycle.
   task automatic loadAndRun(input int len, input int gapPct, input int stopAt, input int abortCycle);
      int         n;
      int         expLen;
      int         cyc;
      bit         ok;
      bit         halted;
      logic [7:0] b;

      n = (len == 0) ? DEPTH : len;
      sendByte(8'(len), gapPct, ok);
      stepCycle();
      bus.in_valid = 1'b0;
      checkOutput("loadEntry", {core_run, busy, done, bus.in_ready}, 64'b0101);

      for (int i = 0; i < n; i++) begin
         b = (presetData.size() > 0) ? presetData.pop_front() : 8'($urandom);
         sendByte(b, gapPct, ok);
         if (ok) writeQ.push_back('{addr: i, data: int'(b)});
      end

      expLen = (stopAt >= 1 && stopAt <= RUN_CYCLES) ? stopAt : RUN_CYCLES;
      runQ.push_back(expLen);

      stepCycle();
      bus.in_valid = 1'b0;
      checkOutput("runEntry", {core_run, busy, bus.in_ready, cycle_count}, {45'd0, 3'b110, 16'd0});
      if (gapPct == 0) checkOutput("backToBackWrites", weStreak, n);

      halted = 1'b0;
      for (cyc = 1; cyc <= 4 * RUN_CYCLES && !halted; cyc++) begin
         if (cyc == abortCycle) begin
            clr = 1'b1;
            #1;
            writeQ.delete();
            runQ.delete();
            checkReset("abortRun");
            stepCycle();
            clr  = 1'b0;
            stop = 1'b0;
            return;
         end
         checkOutput("runCycleCount", cycle_count, cyc - 1);
         stop = 1'(cyc == stopAt);
         stepCycle();
         halted = !core_run;
      end
      checkOutput("haltReached", halted, 64'd1);

      // stop has no effect once halted
      stop = 1'b1;
      for (int k = 0; k < 2; k++) begin
         stepCycle();
         checkOutput("haltHold", {done, core_run, cycle_count}, {46'd0, 2'b10, 16'(expLen)});
      end
      stop = 1'b0;
   endtask

   initial begin : monitor
      int     runLen;
      int     expRun;
      logic   prevRun;
      logic   rulesOk;
      write_t w;
      runLen  = 0;
      prevRun = 1'b0;
      forever begin
         @(negedge clk);
         if (clr) begin
            runLen   = 0;
            prevRun  = 1'b0;
            weStreak = 0;
         end else begin
            if (bus.inst_we) begin
               weStreak++;
               if (writeQ.size() == 0) begin
                  checkOutput("unexpectedWrite", {bus.inst_address, bus.inst_data}, 64'd0);
               end else begin
                  w = writeQ.pop_front();
                  checkOutput("writeAddr", bus.inst_address, w.addr);
                  checkOutput("writeData", bus.inst_data, w.data);
               end
            end else begin
               weStreak = 0;
            end

            rulesOk = (bus.in_ready == !core_run) && (busy || !core_run) && !(done && busy);
            checkOutput("statusRules", rulesOk, 64'd1);

            if (core_run) runLen++;
            if (prevRun && !core_run) begin
               if (runQ.size() == 0) begin
                  checkOutput("unexpectedHalt", runLen, 64'd0);
               end else begin
                  expRun = runQ.pop_front();
                  checkOutput("runLength", runLen, expRun);
                  checkOutput("haltCount", cycle_count, expRun);
                  checkOutput("haltDone", done, 64'd1);
               end
               runLen = 0;
            end
            prevRun = core_run;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 1000000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : applyStimulus
      bit         ok;
      logic [7:0] b;

      clr          = 1'b1;
      stop         = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) stepCycle();
      checkReset("powerOn");
      clr = 1'b0;

      presetData = '{8'hAA, 8'hBB, 8'hCC};
      loadAndRun(3, 0, 0, -1);
      loadAndRun(5, 0, RUN_CYCLES, -1);
      loadAndRun(2, 20, 4, -1);
      loadAndRun(6, 0, 1, -1);

      for (int t = 0; t < 12; t++) begin
         loadAndRun(int'($urandom_range(24, 1)), int'($urandom_range(60, 0)),
                    int'($urandom_range(14, 0)), -1);
      end

      loadAndRun(0, 10, 0, -1);

      // clr in the middle of a payload
      sendByte(8'd8, 30, ok);
      stepCycle();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         sendByte(b, 30, ok);
         if (ok) writeQ.push_back('{addr: i, data: int'(b)});
      end
      stepCycle();
      bus.in_valid = 1'b0;
      clr = 1'b1;
      #1;
      checkOutput("abortLoadDrained", writeQ.size(), 64'd0);
      writeQ.delete();
      runQ.delete();
      checkReset("abortLoad");
      stepCycle();
      clr = 1'b0;

      loadAndRun(4, 0, 0, 3);
      loadAndRun(1, 0, 0, -1);

      repeat (3) stepCycle();
      checkOutput("writeQueueDrained", writeQ.size(), 64'd0);
      checkOutput("runQueueDrained", runQ.size(), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
